// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter for the ALU (src0) and load (src1) writeback paths.
// Define WB_ARB_RR_EN for round-robin on different-rd contention; default is fixed load priority.
module wb_port_arbiter #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          s0_valid,
    input  logic [4:0]    s0_rd,
    input  logic [DW-1:0] s0_data,
    output logic          s0_ready,
    input  logic          s1_valid,
    input  logic [4:0]    s1_rd,
    input  logic [DW-1:0] s1_data,
    output logic          s1_ready,
    output logic          wr_en,
    output logic [31:0]   wr_sel,
    output logic [DW-1:0] wr_data,
    output logic [31:0]   busy
);

    localparam logic [4:0] XZR = 5'd31;

    // Bit 0 is src0 and bit 1 is src1 in every two-bit vector below.
    logic [1:0]    r_vld;
    logic [1:0]    r_old;
    logic [4:0]    r_rd   [2];
    logic [DW-1:0] r_data [2];
    logic          r_wr_en;
    logic [31:0]   r_wr_sel;
    logic [DW-1:0] r_wr_data;

`ifdef WB_ARB_RR_EN
    typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_e;
    src_e r_rr_ptr;
`endif

    logic [1:0] w_grant;
    logic [1:0] w_ready;
    logic [1:0] w_enq;
    logic [1:0] w_surv;
    logic       w_both;
    logic       w_any;
    logic       w_gnt_idx;

    assign w_both = r_vld[0] & r_vld[1];

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_grant = r_vld;
        if (w_both) begin
            if (r_rd[0] == r_rd[1]) begin
                // Same destination: the older entry must write first.
                w_grant = r_old[0] ? 2'b01 : 2'b10;
            end else begin
`ifdef WB_ARB_RR_EN
                w_grant = (r_rr_ptr == SRC1) ? 2'b10 : 2'b01;
`else
                w_grant = 2'b10;
`endif
            end
        end
    end

    assign w_any     = |w_grant;
    assign w_gnt_idx = w_grant[1];
    assign w_ready   = ~r_vld | w_grant;
    assign w_surv    = r_vld & ~w_grant;
    assign w_enq[0]  = s0_valid & w_ready[0] & (s0_rd != XZR);
    assign w_enq[1]  = s1_valid & w_ready[1] & (s1_rd != XZR);

    assign s0_ready = w_ready[0];
    assign s1_ready = w_ready[1];

    always_comb begin
        busy = '0;
        for (int n = 0; n < 2; n++) begin
            if (r_vld[n]) busy = busy | (32'b1 << r_rd[n]);
        end
    end

    // At most one buffer survives a cycle in which both were valid, so a surviving entry
    // is older exactly when the other side enqueues behind it; a same-edge tie favours src1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld     <= '0;
            r_old     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_sel  <= '0;
            r_wr_data <= '0;
        end else begin
            r_vld     <= w_enq | w_surv;
            r_old[0]  <= w_surv[0] & w_enq[1];
            r_old[1]  <= w_enq[0] & (w_surv[1] | w_enq[1]);
            r_wr_en   <= w_any;
            r_wr_sel  <= w_any ? (32'b1 << r_rd[w_gnt_idx]) : 32'b0;
            if (w_any) r_wr_data <= r_data[w_gnt_idx];
        end
    end

`ifdef WB_ARB_RR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= SRC0;
        end else if (w_both) begin
            r_rr_ptr <= w_gnt_idx ? SRC0 : SRC1;
        end
    end
`endif

    // NOTE: buffer payload has no reset; r_vld qualifies it, so stale contents are never used.
    always_ff @(posedge clk) begin
        if (w_enq[0]) begin
            r_rd[0]   <= s0_rd;
            r_data[0] <= s0_data;
        end
        if (w_enq[1]) begin
            r_rd[1]   <= s1_rd;
            r_data[1] <= s1_data;
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_sel  = r_wr_sel;
    assign wr_data = r_wr_data;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised and directed bench for wb_port_arbiter against an age-stamped entry model.
module tb_wb_port_arbiter;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          s0_valid, s1_valid;
    logic [4:0]    s0_rd, s1_rd;
    logic [DW-1:0] s0_data, s1_data;
    logic          s0_ready, s1_ready;
    logic          wr_en;
    logic [31:0]   wr_sel;
    logic [DW-1:0] wr_data;
    logic [31:0]   busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each source holds at most one entry stamped with a global
    // enqueue sequence number; smaller stamp means earlier instruction.
    bit            m_v   [2];
    logic [4:0]    m_rd  [2];
    logic [DW-1:0] m_d   [2];
    int unsigned   m_seq [2];
    int unsigned   seq_ctr;
    bit            m_ptr;
    logic          e_en;
    logic [31:0]   e_sel;
    logic [DW-1:0] e_data;

    logic [31:0]   wq_sel [$];
    logic [DW-1:0] wq_data [$];

    wb_port_arbiter #(.DW(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s0_valid (s0_valid),
        .s0_rd    (s0_rd),
        .s0_data  (s0_data),
        .s0_ready (s0_ready),
        .s1_valid (s1_valid),
        .s1_rd    (s1_rd),
        .s1_data  (s1_data),
        .s1_ready (s1_ready),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) m_v[n] = 1'b0;
        m_ptr   = 1'b0;
        seq_ctr = 0;
        e_en    = 1'b0;
        e_sel   = '0;
        e_data  = '0;
    endtask

    function automatic int pick();
        if (m_v[0] && m_v[1]) begin
            if (m_rd[0] == m_rd[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
`ifdef WB_ARB_RR_EN
            return m_ptr ? 1 : 0;
`else
            return 1;
`endif
        end
        if (m_v[0]) return 0;
        if (m_v[1]) return 1;
        return -1;
    endfunction

    task automatic drive(input bit v0, input logic [4:0] r0, input logic [DW-1:0] d0,
                         input bit v1, input logic [4:0] r1, input logic [DW-1:0] d1);
        s0_valid = v0; s0_rd = r0; s0_data = d0;
        s1_valid = v1; s1_rd = r1; s1_data = d1;
    endtask

    // Called just after a falling edge with inputs set; ends just after the next falling edge.
    task automatic step();
        int          g;
        bit          rdy0, rdy1, acc0, acc1;
        logic [31:0] b;
        g    = pick();
        rdy0 = !m_v[0] || (g == 0);
        rdy1 = !m_v[1] || (g == 1);
        b    = '0;
        for (int n = 0; n < 2; n++) if (m_v[n]) b = b | (32'b1 << m_rd[n]);
        check("s0_ready", s0_ready, rdy0);
        check("s1_ready", s1_ready, rdy1);
        check("busy", busy, b);
        acc0 = s0_valid && rdy0;
        acc1 = s1_valid && rdy1;
        @(posedge clk);
        if (g >= 0) begin
            if (m_v[0] && m_v[1]) m_ptr = (g == 0);
            e_en   = 1'b1;
            e_sel  = 32'b1 << m_rd[g];
            e_data = m_d[g];
            m_v[g] = 1'b0;
        end else begin
            e_en  = 1'b0;
            e_sel = '0;
        end
        if (acc1 && s1_rd != 5'd31) begin
            m_v[1] = 1'b1; m_rd[1] = s1_rd; m_d[1] = s1_data; m_seq[1] = seq_ctr; seq_ctr++;
        end
        if (acc0 && s0_rd != 5'd31) begin
            m_v[0] = 1'b1; m_rd[0] = s0_rd; m_d[0] = s0_data; m_seq[0] = seq_ctr; seq_ctr++;
        end
        @(negedge clk);
        check("wr_en", wr_en, e_en);
        check("wr_sel", wr_sel, e_sel);
        check("wr_data", wr_data, e_data);
        if (wr_en === 1'b1) begin
            wq_sel.push_back(wr_sel);
            wq_data.push_back(wr_data);
        end
    endtask

    task automatic idle(input int cycles);
        drive(0, '0, '0, 0, '0, '0);
        repeat (cycles) step();
    endtask

    task automatic clear_log();
        wq_sel.delete();
        wq_data.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, '0, '0, 0, '0, '0);
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_sel", wr_sel, 32'h0);
        check("rst_wr_data", wr_data, 64'h0);
        check("rst_busy", busy, 32'h0);
        check("rst_s0_ready", s0_ready, 1'b1);
        check("rst_s1_ready", s1_ready, 1'b1);
        reset_n = 1'b1;

        // Single write
        drive(1, 5'd3, 64'h1234, 0, '0, '0);
        step();
        check("single_busy", busy, 32'h8);
        idle(1);
        check("single_wr_en", wr_en, 1'b1);
        check("single_wr_sel", wr_sel, 32'h0000_0008);
        check("single_wr_data", wr_data, 64'h1234);
        idle(1);
        check("single_wr_en_drop", wr_en, 1'b0);

        // XZR drop
        drive(0, '0, '0, 1, 5'd31, 64'hFF);
        check("xzr_s1_ready", s1_ready, 1'b1);
        step();
        check("xzr_busy", busy, 32'h0);
        idle(2);
        check("xzr_no_write", wr_en, 1'b0);

        // Reset mid-operation
        drive(1, 5'd5, 64'hA, 0, '0, '0);
        step();
        check("midrst_busy_before", busy, 32'h20);
        drive(0, '0, '0, 0, '0, '0);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("midrst_busy", busy, 32'h0);
        check("midrst_s0_ready", s0_ready, 1'b1);
        check("midrst_s1_ready", s1_ready, 1'b1);
        check("midrst_wr_en", wr_en, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_wr_en_later", wr_en, 1'b0);
        reset_n = 1'b1;
        idle(1);

        // Same-rd ordering, staggered then simultaneous
        clear_log();
        drive(1, 5'd7, 64'h11, 0, '0, '0);
        step();
        drive(0, '0, '0, 1, 5'd7, 64'h22);
        step();
        idle(3);
        check("order_count", wq_data.size(), 2);
        check("order_first", wq_data[0], 64'h11);
        check("order_second", wq_data[1], 64'h22);
        clear_log();
        drive(1, 5'd7, 64'h11, 1, 5'd7, 64'h22);
        step();
        idle(3);
        check("tie_count", wq_data.size(), 2);
        check("tie_first", wq_data[0], 64'h22);
        check("tie_second", wq_data[1], 64'h11);

        // Contention on different destinations
        clear_log();
        drive(1, 5'd1, 64'hA1, 1, 5'd2, 64'hB2);
        repeat (6) step();
`ifdef WB_ARB_RR_EN
        check("rr_alternate", wq_sel[wq_sel.size()-1] ^ wq_sel[wq_sel.size()-2], 32'h6);
`else
        check("fixed_wr_sel", wr_sel, 32'h4);
        check("fixed_s0_blocked", s0_ready, 1'b0);
`endif
        idle(4);

        // Back-to-back from src0
        clear_log();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 5'(i), 64'(i * 16), 0, '0, '0);
            check("b2b_s0_ready", s0_ready, 1'b1);
            step();
        end
        idle(3);
        check("b2b_count", wq_sel.size(), 4);
        for (int i = 0; i < 4; i++) check("b2b_sel", wq_sel[i], 32'b1 << (i + 1));

        // Random traffic; small rd range forces same-rd collisions
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 9) < 7,
                  ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3)),
                  {$urandom, $urandom},
                  $urandom_range(0, 9) < 7,
                  ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3)),
                  {$urandom, $urandom});
            step();
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between two writeback sources: the ALU result path (src0) and the load/memory result path (src1). Each source has a one-entry holding buffer. A grant each cycle drives a registered one-hot write select (`wr_sel`, bit n = X_n), data and enable into the register file. A `busy` bitmap of buffered destinations is exported for hazard detection in decode.

## Interface
Parameters:
- `DW`, 64: data width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s0_valid`  in  1  ALU result valid.
- `s0_rd`  in  5  ALU destination register.
- `s0_data`  in  DW  ALU result.
- `s0_ready`  out  1  ALU entry accepted this cycle when high with `s0_valid`.
- `s1_valid`, `s1_rd`, `s1_data`, `s1_ready`: same as the s0 signals, for the load path.
- `wr_en`  out  1  register-file write strobe (registered).
- `wr_sel`  out  32  one-hot write select, bit `rd` set (registered).
- `wr_data`  out  DW  write data (registered).
- `busy`  out  32  OR of one-hot encodings of all buffered `rd`s (combinational from state).

## Operation
- Per-source buffer state: `vld`, `rd`, `data`, `old`. The `old` bit is set if the entry was enqueued strictly before the other buffer's current entry.
- **Enqueue:**
  - `sN_ready = !bufN.vld | grantN`. Ready depends only on state, never on `sN_valid`.
  - An accept with `rd == 31` (XZR) is dropped: ready is asserted but nothing is buffered and no write occurs.
- **Grant (per cycle, among valid buffers):**
  - Only one valid: grant it.
  - Both valid, same `rd`: grant the entry with `old` set. If enqueued in the same cycle, src1 is older (the load belongs to the earlier instruction).
  - Both valid, different `rd`: policy set by the configuration macro.
- **Granted entry, next edge:**
  - `wr_en` = 1.
  - `wr_sel` = `32'b1 << rd`.
  - `wr_data` = data.
  - The buffer clears unless refilled by the same edge's enqueue.
- **No grant:** `wr_en` = 0 and `wr_sel` = 0. `wr_data` holds its last value.
- `busy` excludes entries being granted this cycle only after the edge, i.e. it reflects buffer state.

## Timing
- **Reset (async assert):**
  - All buffers invalid, all `old` bits 0, round-robin pointer = src0.
  - `wr_en` = 0, `wr_sel` = 0, `wr_data` = 0, `busy` = 0.
  - `s0_ready` = `s1_ready` = 1.
- Reset assertion mid-operation discards buffered entries. No write issues after reset assertion.
- Deassertion is synchronised externally. The first accept can occur at the first edge after deassertion.
- **Latency:**
  - Accept at edge N. If uncontended, grant in cycle N→N+1, and `wr_en`/`wr_sel` are visible after edge N+1.
  - Contended loser: +1 cycle per lost arbitration.
- **Throughput:** 1 write/cycle total. Each source sustains 1/cycle when uncontended, because grant and enqueue coexist in one edge.
- **Simultaneous events:**
  - Enqueue into a buffer being granted: the new entry replaces it, and its `old` bit is recomputed against the surviving other entry.
  - Both sources enqueue into empty buffers: src1 `old` = 1.
- Worst-case wait is 1 cycle with round-robin; it is unbounded under fixed priority if src1 streams.

## Configuration
- `WB_ARB_RR_EN` defined: for different-`rd` contention, grant goes to the source named by a round-robin pointer. The pointer flips to the other source after any contended grant. Uncontended grants leave the pointer unchanged.
- `WB_ARB_RR_EN` undefined: fixed priority, src1 (load) always wins different-`rd` contention. No pointer register is built.
- The same-`rd` age rule applies in both builds.

## Test plan
- **Reset mid-operation.** Stimulus: s0 accepts rd=5, data=0xA; `reset_n` drops before the write issues. Required response: `wr_en` stays 0, `busy` = 0, both readies = 1 immediately.
- **Single write.** Stimulus: s0 valid, rd=3, data=0x1234. Required response: `s0_ready` = 1; `busy` = 0x8 the next cycle; then `wr_en` = 1, `wr_sel` = 0x0000_0008, `wr_data` = 0x1234 for exactly one cycle.
- **XZR drop.** Stimulus: s1 valid, rd=31, data=0xFF. Required response: `s1_ready` = 1; `busy` stays 0; `wr_en` never asserts.
- **Same-rd order.** Stimulus: s0 enqueues rd=7/0x11 one cycle, s1 enqueues rd=7/0x22 the next while s0 is blocked. Required response: writes occur in order 0x11 then 0x22. If both are enqueued in the same cycle, the order is 0x22 then 0x11.
- **Contention.** Stimulus: both sources continuously valid with rd=1 and rd=2.
  - With `WB_ARB_RR_EN`: `wr_sel` alternates 0x2/0x4 and each ready toggles.
  - Without it: `wr_sel` stays 0x4 and `s0_ready` stays 0 until s1 stops.
- **Back-to-back.** Stimulus: s0 streams rd=1,2,3,4 on consecutive cycles with s1 idle. Required response: `s0_ready` = 1 throughout; `wr_sel` = 0x2, 0x4, 0x8, 0x10 on consecutive cycles.
